count_snapshot_buffer: RTL and testbench

Multi-channel successor to the single-channel window latch. It captures CH ring-oscillator window counts when window_done pulses, in either raw mode or averaged mode (mean over 2^AVG_LOG2 windows). Each result is published with a sequence number over a valid/ready handshake to the UART framing logic. Drops caused by a stalled consumer are counted, never silently lost.

---
 rtl/count_snapshot_buffer_pkg.sv | 12 +
 rtl/count_snapshot_buffer_if.sv | 9 +
 rtl/count_snapshot_buffer_accum.sv | 22 ++
 rtl/count_snapshot_buffer.sv | 60 ++++++
 tb/tb_count_snapshot_buffer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_snapshot_buffer_pkg.sv
// count_pkg: shared widths, mode encodings and lane helper for the snapshot buffer
package count_pkg;
    localparam int CNT_W  = 8;
    localparam int SEQ_W  = 8;
    localparam int DROP_W = 8;
    localparam int LANES  = 4;
    localparam logic MODE_RAW = 1'b0;
    localparam logic MODE_AVG = 1'b1;
    function automatic logic [CNT_W-1:0] lane(input logic [LANES*CNT_W-1:0] bus, input int i);
        return bus[i*CNT_W +: CNT_W];
    endfunction
endpackage

// File: rtl/count_snapshot_buffer_if.sv
// count_snapshot_buffer_if: valid/ready snapshot stream towards the UART framer
interface count_snapshot_buffer_if import count_pkg::*; #(parameter int CH = LANES, parameter int W = CNT_W);
    logic             out_valid;
    logic             out_ready;
    logic [CH*W-1:0]  out_data;
    logic [SEQ_W-1:0] out_seq;
    modport master(output out_valid, out_data, out_seq, input out_ready);
    modport slave(input out_valid, out_data, out_seq, output out_ready);
endinterface

// File: rtl/count_snapshot_buffer_accum.sv
// count_accum: one channel's window-sum accumulator with truncating mean output
module count_accum import count_pkg::*; #(
    parameter int W        = CNT_W,
    parameter int AVG_LOG2 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         add,
    input  logic         fin,
    input  logic [W-1:0] cnt,
    output logic [W-1:0] res
);
    // AVG_LOG2 guard bits: 2^AVG_LOG2 full-scale samples never overflow
    logic [W+AVG_LOG2-1:0] acc, sum;
    assign sum = acc + (W+AVG_LOG2)'(cnt);
    assign res = W'(sum >> AVG_LOG2);
    always_ff @(posedge clk) begin
        if (rst || clr || fin) acc <= '0;
        else if (add) acc <= sum;
    end
endmodule

// File: rtl/count_snapshot_buffer.sv
// count_snapshot_buffer: captures raw or averaged oscillator counts and publishes them with seq/drop tracking
module count_snapshot_buffer import count_pkg::*; #(
    parameter int CH       = LANES,
    parameter int W        = CNT_W,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              window_done,
    input  logic [CH*W-1:0]   count,
    input  logic              mode,
    input  logic              clr_drop,
    output logic [DROP_W-1:0] drop_cnt,
    count_snapshot_buffer_if.master snap
);
    logic                mode_q;
    logic [AVG_LOG2-1:0] acc_cnt;
    logic [CH*W-1:0]     avg_res, result;
    logic                mode_chg, wd, avg_wd, last, produce, take;
    // a mode change restarts averaging and swallows that cycle's window
    assign mode_chg = mode != mode_q;
    assign wd       = window_done && !mode_chg;
    assign avg_wd   = wd && mode_q == MODE_AVG;
    assign last     = acc_cnt == '1;
    assign produce  = wd && (mode_q == MODE_RAW || last);
    assign take     = produce && (!snap.out_valid || snap.out_ready);
    assign result   = mode_q == MODE_AVG ? avg_res : count;
    for (genvar g = 0; g < CH; g++) begin : g_acc
        count_accum #(.W(W), .AVG_LOG2(AVG_LOG2)) u_acc (
            .clk(clk),
            .rst(rst),
            .clr(mode_chg),
            .add(avg_wd && !last),
            .fin(avg_wd && last),
            .cnt(count[g*W +: W]),
            .res(avg_res[g*W +: W])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q         <= MODE_RAW;
            acc_cnt        <= '0;
            snap.out_valid <= 1'b0;
            snap.out_data  <= '0;
            snap.out_seq   <= '0;
            drop_cnt       <= '0;
        end else begin
            mode_q  <= mode;
            acc_cnt <= mode_chg ? '0 : avg_wd ? acc_cnt + 1'b1 : acc_cnt;
            if (take) begin
                snap.out_valid <= 1'b1;
                snap.out_data  <= result;
                snap.out_seq   <= snap.out_seq + 1'b1;
            end else if (snap.out_valid && snap.out_ready) begin
                snap.out_valid <= 1'b0;
            end
            drop_cnt <= clr_drop ? '0 : (produce && !take && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
        end
    end
endmodule

// File: tb/tb_count_snapshot_buffer.sv
// tb_count_snapshot_buffer: randomized scenarios checked against a sum/divide reference model
module tb_count_snapshot_buffer;
    import count_pkg::*;
    localparam int NAVG = 4;
    logic clk = 0, rst = 1, window_done = 0, mode = 0, clr_drop = 0, rdy = 0;
    logic [31:0] count = '0;
    logic [7:0] drop_cnt;
    int n_vec = 0, n_err = 0;
    logic m_valid, m_mode;
    logic [31:0] m_data;
    logic [7:0] m_seq, m_drop;
    int sums[4];
    int m_n;

    count_snapshot_buffer_if #(.CH(4), .W(8)) snap ();
    assign snap.out_ready = rdy;

    count_snapshot_buffer #(.CH(4), .W(8), .AVG_LOG2(2)) dut (
        .clk(clk), .rst(rst), .window_done(window_done), .count(count),
        .mode(mode), .clr_drop(clr_drop), .drop_cnt(drop_cnt), .snap(snap)
    );

    always #5 clk = ~clk;

    // reference model advances on the current inputs, then one clock elapses
    task automatic tick();
        logic [31:0] res = '0;
        bit have = 0;
        if (rst) begin
            m_valid = 0; m_data = '0; m_seq = '0; m_drop = '0; m_mode = 0; m_n = 0;
            foreach (sums[i]) sums[i] = 0;
        end else begin
            if (mode !== m_mode) begin
                m_mode = mode; m_n = 0;
                foreach (sums[i]) sums[i] = 0;
            end else if (window_done) begin
                if (!m_mode) begin
                    res = count; have = 1;
                end else begin
                    foreach (sums[i]) sums[i] += int'(lane(count, i));
                    m_n++;
                    if (m_n == NAVG) begin
                        foreach (sums[i]) res[i*8 +: 8] = 8'(sums[i] / NAVG);
                        foreach (sums[i]) sums[i] = 0;
                        m_n = 0; have = 1;
                    end
                end
            end
            if (have && (!m_valid || rdy)) begin
                m_data = res; m_valid = 1; m_seq = m_seq + 8'd1;
            end else if (have) begin
                if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (clr_drop) m_drop = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; window_done = 0; rdy = 0; mode = 0; clr_drop = 0;
        tick(); tick();
        n_vec++;
        if ({snap.out_valid, snap.out_data, snap.out_seq, drop_cnt} !== 49'd0) begin
            n_err++; $display("FAIL reset: got v=%0b d=%h s=%0d dr=%0d want all zero", snap.out_valid, snap.out_data, snap.out_seq, drop_cnt);
        end
        rst = 0;
    endtask

    task automatic test_raw();
        window_done = 1; rdy = 1; count = 32'h78563412;
        tick();
        window_done = 0;
        n_vec++;
        if ({snap.out_valid, snap.out_data, snap.out_seq} !== {1'b1, 32'h78563412, 8'd1}) begin
            n_err++; $display("FAIL raw_publish: got v=%0b d=%h s=%0d want v=1 d=78563412 s=1", snap.out_valid, snap.out_data, snap.out_seq);
        end
        tick();
        n_vec++;
        if (snap.out_valid !== 1'b0) begin
            n_err++; $display("FAIL raw_accept: got v=%0b want 0", snap.out_valid);
        end
    endtask

    task automatic test_avg();
        mode = 1; window_done = 0; rdy = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            window_done = 1;
            count = {8'($urandom), 8'($urandom), 8'd255, 8'(10 + k)};
            tick();
            n_vec++;
            if (k < 3 && snap.out_valid !== 1'b0) begin
                n_err++; $display("FAIL avg_early k=%0d: got v=%0b want 0", k, snap.out_valid);
            end
        end
        window_done = 0;
        n_vec++;
        if ({snap.out_valid, lane(snap.out_data, 0), lane(snap.out_data, 1)} !== {1'b1, 8'd11, 8'd255}) begin
            n_err++; $display("FAIL avg_result: got v=%0b l0=%0d l1=%0d want v=1 l0=11 l1=255", snap.out_valid, lane(snap.out_data, 0), lane(snap.out_data, 1));
        end
        n_vec++;
        if ({snap.out_valid, snap.out_data, snap.out_seq, drop_cnt} !== {m_valid, m_data, m_seq, m_drop}) begin
            n_err++; $display("FAIL avg_model: got d=%h s=%0d want d=%h s=%0d", snap.out_data, snap.out_seq, m_data, m_seq);
        end
        tick();
    endtask

    task automatic test_drop_clr();
        logic [31:0] c0;
        mode = 0; window_done = 0; rdy = 1;
        tick();
        rdy = 0; window_done = 1;
        c0 = $urandom; count = c0;
        tick();
        count = $urandom; tick();
        count = $urandom; tick();
        n_vec++;
        if ({snap.out_data, drop_cnt} !== {c0, 8'd2}) begin
            n_err++; $display("FAIL drop_hold: got d=%h dr=%0d want d=%h dr=2", snap.out_data, drop_cnt, c0);
        end
        clr_drop = 1; count = $urandom;
        tick();
        clr_drop = 0; window_done = 0;
        n_vec++;
        if ({snap.out_data, drop_cnt} !== {c0, 8'd0}) begin
            n_err++; $display("FAIL drop_clr: got d=%h dr=%0d want d=%h dr=0", snap.out_data, drop_cnt, c0);
        end
        rdy = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] s, d;
        logic [31:0] c;
        window_done = 1; rdy = 0; count = $urandom;
        tick();
        s = snap.out_seq; d = drop_cnt;
        c = $urandom; count = c; rdy = 1;
        tick();
        window_done = 0;
        n_vec++;
        if ({snap.out_valid, snap.out_data, snap.out_seq, drop_cnt} !== {1'b1, c, s + 8'd1, d}) begin
            n_err++; $display("FAIL back_to_back: got v=%0b d=%h s=%0d dr=%0d want v=1 d=%h s=%0d dr=%0d", snap.out_valid, snap.out_data, snap.out_seq, drop_cnt, c, s + 8'd1, d);
        end
        tick();
    endtask

    task automatic test_mode_toggle();
        logic [7:0] d;
        logic [31:0] c;
        mode = 1; window_done = 0; rdy = 1;
        tick();
        window_done = 1;
        count = $urandom; tick();
        count = $urandom; tick();
        d = drop_cnt;
        mode = 0; count = $urandom;
        tick();
        n_vec++;
        if ({snap.out_valid, drop_cnt} !== {1'b0, d}) begin
            n_err++; $display("FAIL toggle_discard: got v=%0b dr=%0d want v=0 dr=%0d", snap.out_valid, drop_cnt, d);
        end
        c = $urandom; count = c;
        tick();
        window_done = 0;
        n_vec++;
        if ({snap.out_valid, snap.out_data} !== {1'b1, c}) begin
            n_err++; $display("FAIL toggle_raw: got v=%0b d=%h want v=1 d=%h", snap.out_valid, snap.out_data, c);
        end
        tick();
    endtask

    task automatic test_seq_wrap();
        bit wrapped = 0;
        logic [7:0] prev;
        rdy = 1; window_done = 1;
        for (int k = 0; k < 256; k++) begin
            prev = snap.out_seq;
            count = $urandom;
            tick();
            if (prev == 8'd255 && snap.out_seq == 8'd0) wrapped = 1;
            n_vec++;
            if ({snap.out_valid, snap.out_data, snap.out_seq, drop_cnt} !== {m_valid, m_data, m_seq, m_drop}) begin
                n_err++; $display("FAIL seq_stream k=%0d: got d=%h s=%0d want d=%h s=%0d", k, snap.out_data, snap.out_seq, m_data, m_seq);
            end
        end
        n_vec++;
        if (wrapped !== 1'b1) begin
            n_err++; $display("FAIL seq_wrap: got wrap=%0b want 1", wrapped);
        end
        window_done = 0;
        tick();
    endtask

    task automatic test_drop_sat();
        logic [31:0] c0;
        window_done = 1; rdy = 0;
        c0 = $urandom; count = c0;
        tick();
        for (int k = 0; k < 300; k++) begin
            count = $urandom;
            tick();
        end
        window_done = 0;
        n_vec++;
        if ({snap.out_valid, snap.out_data, drop_cnt} !== {1'b1, c0, 8'd255}) begin
            n_err++; $display("FAIL drop_sat: got v=%0b d=%h dr=%0d want v=1 d=%h dr=255", snap.out_valid, snap.out_data, drop_cnt, c0);
        end
        clr_drop = 1; rdy = 1;
        tick();
        clr_drop = 0;
    endtask

    task automatic test_reset_mid_avg();
        mode = 1; window_done = 0; rdy = 0;
        tick();
        window_done = 1;
        count = $urandom; tick();
        count = $urandom; tick();
        rst = 1;
        tick();
        rst = 0;
        n_vec++;
        if ({snap.out_valid, snap.out_data, snap.out_seq, drop_cnt} !== 49'd0) begin
            n_err++; $display("FAIL reset_mid_avg: got v=%0b d=%h s=%0d dr=%0d want all zero", snap.out_valid, snap.out_data, snap.out_seq, drop_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            count = $urandom;
            tick();
        end
        window_done = 0;
        n_vec++;
        if ({snap.out_valid, snap.out_data, snap.out_seq, drop_cnt} !== {m_valid, m_data, m_seq, m_drop} || snap.out_valid !== 1'b1) begin
            n_err++; $display("FAIL avg_after_reset: got v=%0b d=%h s=%0d want v=1 d=%h s=%0d", snap.out_valid, snap.out_data, snap.out_seq, m_data, m_seq);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            window_done = ($urandom_range(0, 2) != 0);
            count = $urandom;
            rdy = ($urandom_range(0, 1) != 0);
            clr_drop = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            tick();
            n_vec++;
            if ({snap.out_valid, snap.out_data, snap.out_seq, drop_cnt} !== {m_valid, m_data, m_seq, m_drop}) begin
                n_err++; $display("FAIL random k=%0d: got v=%0b d=%h s=%0d dr=%0d want v=%0b d=%h s=%0d dr=%0d", k, snap.out_valid, snap.out_data, snap.out_seq, drop_cnt, m_valid, m_data, m_seq, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_avg();
        test_drop_clr();
        test_back_to_back();
        test_mode_toggle();
        test_seq_wrap();
        test_drop_sat();
        test_reset_mid_avg();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
